// File: rtl/uart_pkg.sv
// ============================================================================
// uart_pkg : shared constants and state encoding for the UART frame parser
// Revision : 1.0
// ============================================================================
`default_nettype none

package uart_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_CHK  = 2'b01;
    localparam logic [1:0] ERR_LEN  = 2'b10;
    localparam logic [1:0] ERR_TMO  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CMD     = 3'd1,
        ST_LEN     = 3'd2,
        ST_PAYLOAD = 3'd3,
        ST_CHECK   = 3'd4,
        ST_EMIT    = 3'd5
    } state_t;

endpackage

`default_nettype wire

// File: rtl/uart_frame_buf.sv
// ============================================================================
// uart_frame_buf : payload register array, one write port, async read port
// Revision : 1.0
// ============================================================================
`default_nettype none

module uart_frame_buf #(
    parameter int DEPTH = 16,
    parameter int AW    = 5
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [7:0] mem [DEPTH];

    // Addresses are one bit wider than the array needs; out-of-range is guarded.
    always_ff @(posedge clk) begin
        if (we && (32'(waddr) < DEPTH)) begin
            mem[waddr[IW-1:0]] <= wdata;
        end
    end

    assign rdata = (32'(raddr) < DEPTH) ? mem[raddr[IW-1:0]] : 8'h00;

endmodule

`default_nettype wire

// File: rtl/uart_rx_frame_parser.sv
// ============================================================================
// uart_rx_frame_parser : assembles A5-synced framed commands, checks length and
//                        XOR checksum, then streams the payload on valid/ready
// Revision : 1.0
// ============================================================================
`default_nettype none

module uart_rx_frame_parser
    import uart_pkg::*;
#(
    parameter int MAX_LEN      = 16,
    parameter int TIMEOUT_CLKS = 8700
) (
    input  logic       i_Clock,
    input  logic       i_Reset,
    input  logic       i_Rx_DV,
    input  logic [7:0] i_Rx_Byte,
    output logic [7:0] o_Cmd,
    output logic [7:0] o_Len,
    output logic       o_Frame_Ok,
    output logic [7:0] o_Data,
    output logic       o_Valid,
    input  logic       i_Ready,
    output logic       o_Last,
    output logic       o_Frame_Err,
    output logic [1:0] o_Err_Code,
    output logic       o_Overrun,
    output logic       o_Busy
);

    localparam int              IW        = $clog2(MAX_LEN + 1);
    localparam int              TW        = (TIMEOUT_CLKS > 2) ? $clog2(TIMEOUT_CLKS) : 1;
    localparam logic [TW-1:0]   TMO_LAST  = TW'(TIMEOUT_CLKS - 1);
    localparam logic [7:0]      MAX_LEN_B = 8'(MAX_LEN);

    state_t          state, state_nxt;
    logic [7:0]      cmd_q, cmd_nxt;
    logic [7:0]      len_q, len_nxt;
    logic [7:0]      chk_q, chk_nxt;
    logic [IW-1:0]   idx_q, idx_nxt;
    logic [IW-1:0]   rd_q, rd_nxt;
    logic [TW-1:0]   tmo_q;
    logic [1:0]      err_code_q, err_code_nxt;
    logic            ok_q, ok_nxt;
    logic            err_q, err_nxt;
    logic            ovr_q, ovr_nxt;
    logic            buf_we;
    logic [7:0]      buf_rdata;
    logic            in_frame;
    logic            tmo_hit;
    logic            last_beat;

    assign in_frame  = (state == ST_CMD) || (state == ST_LEN) ||
                       (state == ST_PAYLOAD) || (state == ST_CHECK);
    // A byte arriving in the expiry cycle takes priority over the timeout.
    assign tmo_hit   = in_frame && !i_Rx_DV && (tmo_q == TMO_LAST);
    assign last_beat = (8'(rd_q) == (len_q - 8'd1));

    always_comb begin
        state_nxt    = state;
        cmd_nxt      = cmd_q;
        len_nxt      = len_q;
        chk_nxt      = chk_q;
        idx_nxt      = idx_q;
        rd_nxt       = rd_q;
        err_code_nxt = err_code_q;
        ok_nxt       = 1'b0;
        err_nxt      = 1'b0;
        ovr_nxt      = 1'b0;
        buf_we       = 1'b0;

        case (state)
            ST_IDLE: begin
                if (i_Rx_DV && (i_Rx_Byte == SYNC_BYTE)) begin
                    state_nxt = ST_CMD;
                end
            end
            ST_CMD: begin
                if (i_Rx_DV) begin
                    cmd_nxt   = i_Rx_Byte;
                    chk_nxt   = i_Rx_Byte;
                    state_nxt = ST_LEN;
                end
            end
            ST_LEN: begin
                if (i_Rx_DV) begin
                    len_nxt = i_Rx_Byte;
                    chk_nxt = chk_q ^ i_Rx_Byte;
                    if (i_Rx_Byte > MAX_LEN_B) begin
                        err_nxt      = 1'b1;
                        err_code_nxt = ERR_LEN;
                        state_nxt    = ST_IDLE;
                    end else if (i_Rx_Byte == 8'd0) begin
                        state_nxt = ST_CHECK;
                    end else begin
                        idx_nxt   = '0;
                        state_nxt = ST_PAYLOAD;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (i_Rx_DV) begin
                    buf_we  = 1'b1;
                    chk_nxt = chk_q ^ i_Rx_Byte;
                    idx_nxt = idx_q + 1'b1;
                    if (8'(idx_q) == (len_q - 8'd1)) begin
                        state_nxt = ST_CHECK;
                    end
                end
            end
            ST_CHECK: begin
                if (i_Rx_DV) begin
                    if (i_Rx_Byte == chk_q) begin
                        ok_nxt = 1'b1;
                        if (len_q == 8'd0) begin
                            state_nxt = ST_IDLE;
                        end else begin
                            rd_nxt    = '0;
                            state_nxt = ST_EMIT;
                        end
                    end else begin
                        err_nxt      = 1'b1;
                        err_code_nxt = ERR_CHK;
                        state_nxt    = ST_IDLE;
                    end
                end
            end
            ST_EMIT: begin
                ovr_nxt = i_Rx_DV;
                if (i_Ready) begin
                    if (last_beat) begin
                        state_nxt = ST_IDLE;
                    end else begin
                        rd_nxt = rd_q + 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        if (tmo_hit) begin
            err_nxt      = 1'b1;
            err_code_nxt = ERR_TMO;
            state_nxt    = ST_IDLE;
        end
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state      <= ST_IDLE;
            cmd_q      <= 8'h00;
            len_q      <= 8'h00;
            chk_q      <= 8'h00;
            idx_q      <= '0;
            rd_q       <= '0;
            tmo_q      <= '0;
            err_code_q <= ERR_NONE;
            ok_q       <= 1'b0;
            err_q      <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            state      <= state_nxt;
            cmd_q      <= cmd_nxt;
            len_q      <= len_nxt;
            chk_q      <= chk_nxt;
            idx_q      <= idx_nxt;
            rd_q       <= rd_nxt;
            err_code_q <= err_code_nxt;
            ok_q       <= ok_nxt;
            err_q      <= err_nxt;
            ovr_q      <= ovr_nxt;
            // Saturating idle counter, restarted by any byte or state change.
            if (i_Rx_DV || (state_nxt != state)) begin
                tmo_q <= '0;
            end else if (tmo_q != TMO_LAST) begin
                tmo_q <= tmo_q + 1'b1;
            end
        end
    end

    uart_frame_buf #(
        .DEPTH (MAX_LEN),
        .AW    (IW)
    ) u_buf (
        .clk   (i_Clock),
        .we    (buf_we),
        .waddr (idx_q),
        .wdata (i_Rx_Byte),
        .raddr (rd_q),
        .rdata (buf_rdata)
    );

    assign o_Cmd       = cmd_q;
    assign o_Len       = len_q;
    assign o_Frame_Ok  = ok_q;
    assign o_Frame_Err = err_q;
    assign o_Err_Code  = err_code_q;
    assign o_Overrun   = ovr_q;
    assign o_Busy      = (state != ST_IDLE);
    assign o_Valid     = (state == ST_EMIT);
    assign o_Data      = o_Valid ? buf_rdata : 8'h00;
    assign o_Last      = o_Valid && last_beat;

endmodule

`default_nettype wire
